// File: rtl/reg_file_param.sv
// reg_file_param: parametrised register file, DEPTH = 2**ADDR_W words of DATA_W bits.
// One synchronous write port, two registered read ports with write-first bypass,
// and a clear engine that zeroes one word per cycle while busy is high.
//
// Handshake: there is no valid/ready pair. ce qualifies we, clr and the read-register
// update on the same rising edge. busy=1 means the array is owned by the sweep:
// writes and clear requests presented while busy are dropped, and reads are still served.
module reg_file_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              we,
    input  logic [ADDR_W-1:0] wAdd,
    input  logic [DATA_W-1:0] dIn,
    input  logic [ADDR_W-1:0] rAddA,
    input  logic [ADDR_W-1:0] rAddB,
    input  logic              clr,
    output logic [DATA_W-1:0] dOutA,
    output logic [DATA_W-1:0] dOutB,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;
    logic              sweep_en;
    logic              clr_go;
    logic              do_write;

    logic [DATA_W-1:0] mem [DEPTH];

    // A clear is only accepted from IDLE; it also wins over a write in the same cycle.
    assign clr_go   = ce & clr & (state == IDLE);
    assign do_write = ce & we & ~clr & (state == IDLE);

    // State register: FSM state and sweep counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: start the sweep on an accepted clr, finish after the last word.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (clr_go) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                // The counter stops at the all-ones address, so it never wraps onto word 0.
                if (cnt == {ADDR_W{1'b1}}) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output logic: busy and the sweep strobe come straight from the state register.
    always_comb begin
        busy     = 1'b0;
        sweep_en = 1'b0;
        if (state == CLEAR) begin
            busy     = 1'b1;
            sweep_en = 1'b1;
        end
    end

    // Storage array: the sweep advances regardless of ce; writes only happen outside the sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (sweep_en) begin
            mem[cnt] <= '0;
        end else if (do_write) begin
            mem[wAdd] <= dIn;
        end
    end

    // Registered read ports with write-first bypass; sweep zeros are never bypassed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dOutA <= '0;
            dOutB <= '0;
        end else if (ce) begin
            dOutA <= (do_write && (rAddA == wAdd)) ? dIn : mem[rAddA];
            dOutB <= (do_write && (rAddB == wAdd)) ? dIn : mem[rAddB];
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed testbench for reg_file_param (DATA_W=8, ADDR_W=3).
module tb_reg_file_param;

    logic       clk;
    logic       rst;
    logic       ce;
    logic       we;
    logic [2:0] wAdd;
    logic [7:0] dIn;
    logic [2:0] rAddA;
    logic [2:0] rAddB;
    logic       clr;
    logic [7:0] dOutA;
    logic [7:0] dOutB;
    logic       busy;

    int n_pass;
    int n_total;

    reg_file_param #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce),
        .we    (we),
        .wAdd  (wAdd),
        .dIn   (dIn),
        .rAddA (rAddA),
        .rAddB (rAddB),
        .clr   (clr),
        .dOutA (dOutA),
        .dOutB (dOutB),
        .busy  (busy)
    );

    // Clock and reset defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [2:0] a, input logic [7:0] d);
        ce   = 1'b1;
        we   = 1'b1;
        wAdd = a;
        dIn  = d;
        tick();
        we   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b0; we = 1'b0; clr = 1'b0;
        wAdd = 3'd0; dIn = 8'h00; rAddA = 3'd0; rAddB = 3'd7;
        tick();
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        #2 rst = 1'b0;
        ce = 1'b1;
        tick();
        n_total++;
        if (dOutA !== 8'h00) $display("FAIL reset_rdA: got %h want 00", dOutA); else n_pass++;
        n_total++;
        if (dOutB !== 8'h00) $display("FAIL reset_rdB: got %h want 00", dOutB); else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_busy_post: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_write_read();
        write_word(3'd3, 8'hA5);
        write_word(3'd6, 8'h5A);
        rAddA = 3'd3; rAddB = 3'd6;
        tick();
        n_total++;
        if (dOutA !== 8'hA5) $display("FAIL wr_rdA: got %h want a5", dOutA); else n_pass++;
        n_total++;
        if (dOutB !== 8'h5A) $display("FAIL wr_rdB: got %h want 5a", dOutB); else n_pass++;
        ce = 1'b0; rAddA = 3'd0; rAddB = 3'd1;
        tick();
        tick();
        n_total++;
        if (dOutA !== 8'hA5) $display("FAIL hold_A: got %h want a5", dOutA); else n_pass++;
        n_total++;
        if (dOutB !== 8'h5A) $display("FAIL hold_B: got %h want 5a", dOutB); else n_pass++;
        ce = 1'b1;
    endtask

    task automatic test_bypass();
        write_word(3'd2, 8'h11);
        rAddA = 3'd2; rAddB = 3'd2;
        write_word(3'd2, 8'h22);
        n_total++;
        if (dOutA !== 8'h22) $display("FAIL bypass_A: got %h want 22", dOutA); else n_pass++;
        n_total++;
        if (dOutB !== 8'h22) $display("FAIL bypass_B: got %h want 22", dOutB); else n_pass++;
        tick();
        n_total++;
        if (dOutA !== 8'h22) $display("FAIL bypass_next: got %h want 22", dOutA); else n_pass++;
    endtask

    task automatic test_clear_sweep();
        for (int i = 0; i < 8; i++) write_word(3'(i), 8'(8'h10 + i));
        rAddA = 3'd7; rAddB = 3'd5;
        clr = 1'b1; we = 1'b1; wAdd = 3'd5; dIn = 8'hFF;
        tick();                                  // edge N
        clr = 1'b0; we = 1'b0;
        n_total++;
        if (busy !== 1'b1) $display("FAIL clr_busy_N: got %b want 1", busy); else n_pass++;
        n_total++;
        if (dOutB !== 8'h15) $display("FAIL clr_drop_wr: got %h want 15", dOutB); else n_pass++;
        for (int k = 1; k <= 8; k++) begin
            tick();                              // edge N+k
            n_total++;
            if (busy !== (k < 8)) $display("FAIL clr_busy_N+%0d: got %b want %b", k, busy, (k < 8));
            else n_pass++;
            n_total++;
            if (dOutA !== 8'h17) $display("FAIL clr_rd7_N+%0d: got %h want 17", k, dOutA);
            else n_pass++;
        end
        for (int a = 0; a < 8; a++) begin
            rAddA = 3'(a); rAddB = 3'(7 - a);
            tick();
            n_total++;
            if (dOutA !== 8'h00) $display("FAIL clr_zeroA_%0d: got %h want 00", a, dOutA); else n_pass++;
            n_total++;
            if (dOutB !== 8'h00) $display("FAIL clr_zeroB_%0d: got %h want 00", 7 - a, dOutB); else n_pass++;
        end
    endtask

    task automatic test_busy_interference();
        write_word(3'd0, 8'h55);
        rAddA = 3'd0;
        clr = 1'b1;
        tick();                                  // edge N
        clr = 1'b0;
        tick();                                  // edge N+1 clears word 0
        clr = 1'b1; we = 1'b1; wAdd = 3'd0; dIn = 8'h33;
        tick();                                  // edge N+2
        clr = 1'b0; we = 1'b0;
        n_total++;
        if (dOutA !== 8'h00) $display("FAIL busy_no_bypass: got %h want 00", dOutA); else n_pass++;
        for (int k = 3; k <= 8; k++) begin
            tick();
            n_total++;
            if (busy !== (k < 8)) $display("FAIL busy_int_N+%0d: got %b want %b", k, busy, (k < 8));
            else n_pass++;
        end
        tick();
        n_total++;
        if (dOutA !== 8'h00) $display("FAIL busy_addr0: got %h want 00", dOutA); else n_pass++;
    endtask

    task automatic test_reset_mid_sweep();
        write_word(3'd3, 8'h66);
        write_word(3'd4, 8'h77);
        rAddA = 3'd3; rAddB = 3'd4;
        clr = 1'b1;
        tick();                                  // edge N
        clr = 1'b0;
        n_total++;
        if (dOutA !== 8'h66) $display("FAIL mid_preA: got %h want 66", dOutA); else n_pass++;
        tick(); tick(); tick();                  // edge N+3
        n_total++;
        if (busy !== 1'b1) $display("FAIL mid_busy_pre: got %b want 1", busy); else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy); else n_pass++;
        n_total++;
        if (dOutA !== 8'h00) $display("FAIL mid_rst_A: got %h want 00", dOutA); else n_pass++;
        n_total++;
        if (dOutB !== 8'h00) $display("FAIL mid_rst_B: got %h want 00", dOutB); else n_pass++;
        #3 rst = 1'b0;
        write_word(3'd1, 8'h44);
        rAddA = 3'd1; rAddB = 3'd4;
        tick();
        n_total++;
        if (dOutA !== 8'h44) $display("FAIL post_rst_wr: got %h want 44", dOutA); else n_pass++;
        n_total++;
        if (dOutB !== 8'h00) $display("FAIL post_rst_addr4: got %h want 00", dOutB); else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL post_rst_busy: got %b want 0", busy); else n_pass++;
    endtask

    // Test sequence and final report
    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_write_read();
        test_bypass();
        test_clear_sweep();
        test_busy_interference();
        test_reset_mid_sweep();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
